// File: rtl/fetch_pc_unit_pkg.sv
// Shared defaults and types for the IF-stage program counter and its fetch queue.
// The redirect selector is an enum so the priority between flush and branch is explicit.
package fetch_pc_unit_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_INST_BYTES   = 4;
    localparam int unsigned DEF_QUEUE_DEPTH  = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_FLUSH  = 2'd2
    } redir_e;

endpackage

// File: rtl/fetch_pc_unit_queue.sv
// In-order fetch queue: circular buffer with head/fill/tail pointers carrying a wrap bit.
// Entries are allocated on issue, filled by in-order responses, and popped from the head.
module fetch_queue
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_QUEUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc,
    input  logic [ADDR_WIDTH-1:0] alloc_pc,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  pop,
    input  logic                  kill_all,
    output logic                  full,
    output logic                  head_filled,
    output logic                  head_stale,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]           head_q, head_d;
    logic [PW:0]           fill_q, fill_d;
    logic [PW:0]           tail_q, tail_d;
    logic [PW:0]           count;
    logic [PW-1:0]         head_idx, fill_idx, tail_idx;
    logic                  fill_en;
    logic [DEPTH-1:0]      tail_hit, fill_hit;
    logic [DEPTH-1:0]      filled_q, stale_q;
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    assign head_idx = head_q[PW-1:0];
    assign fill_idx = fill_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    assign count = tail_q - head_q;
    assign full  = (count == (PW+1)'(DEPTH));

    // A response only lands if some allocated entry is still waiting for data.
    assign fill_en = fill && (fill_q != tail_q);

    assign head_d = head_q + (PW+1)'(pop);
    assign fill_d = fill_q + (PW+1)'(fill_en);
    assign tail_d = tail_q + (PW+1)'(alloc);

    assign head_filled = (count != '0) && filled_q[head_idx];
    assign head_stale  = stale_q[head_idx];
    assign head_pc     = pc_q[head_idx];
    assign head_data   = data_q[head_idx];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
        assign tail_hit[gi] = alloc && (tail_idx == PW'(gi));
        assign fill_hit[gi] = fill_en && (fill_idx == PW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
        end
    end

    // Killing marks every slot; a fresh allocation clears the mark, so free slots need no care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filled_q <= '0;
            stale_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tail_hit[i]) begin
                    pc_q[i]     <= alloc_pc;
                    filled_q[i] <= 1'b0;
                    stale_q[i]  <= 1'b0;
                end else begin
                    if (fill_hit[i]) begin
                        data_q[i]   <= fill_data;
                        filled_q[i] <= 1'b1;
                    end
                    if (kill_all) begin
                        stale_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter: holds the PC, selects redirect targets and issues fetch
// requests into an in-order queue that delivers {pc, instruction} to decode.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned          DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned          INST_BYTES   = DEF_INST_BYTES,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned          QUEUE_DEPTH  = DEF_QUEUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush_en,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target;
    redir_e                redir_sel;
    logic                  redirect;
    logic                  alloc;
    logic                  pop;
    logic                  q_full;
    logic                  head_filled;
    logic                  head_stale;

    // Flush outranks branch when both arrive in the same cycle.
    always_comb begin
        redir_sel = REDIR_NONE;
        if (flush_en) begin
            redir_sel = REDIR_FLUSH;
        end else if (branch_flag) begin
            redir_sel = REDIR_BRANCH;
        end
    end

    always_comb begin
        target = '0;
        case (redir_sel)
            REDIR_FLUSH:  target = flush_addr & ALIGN_MASK;
            REDIR_BRANCH: target = branch_addr & ALIGN_MASK;
            default:      target = '0;
        endcase
    end

    assign redirect  = (redir_sel != REDIR_NONE);
    assign req_valid = !rst && !stall && !redirect && !q_full;
    assign req_addr  = pc_q;
    assign alloc     = req_valid && req_ready;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if (alloc) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Stale heads drain on their own; live heads wait for decode to take them.
    assign pop        = head_filled && (head_stale || inst_ready);
    assign inst_valid = head_filled && !head_stale;

    fetch_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .alloc       (alloc),
        .alloc_pc    (pc_q),
        .fill        (resp_valid),
        .fill_data   (resp_data),
        .pop         (pop),
        .kill_all    (redirect),
        .full        (q_full),
        .head_filled (head_filled),
        .head_stale  (head_stale),
        .head_pc     (inst_pc),
        .head_data   (inst_data)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, hand sequences for the queue-full,
// in-flight branch and mid-burst reset cases, then random traffic against a queue model.
module tb_fetch_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush_en, branch_flag;
    logic [31:0] flush_addr, branch_addr;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc, inst_data;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush_en    (flush_en),
        .flush_addr  (flush_addr),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .inst_data   (inst_data),
        .inst_ready  (inst_ready)
    );

    // Reference model: list of allocated fetches in program order plus the memory's pending list.
    typedef struct {
        logic [31:0] pc;
        bit          filled;
        bit          stale;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mem_q[$];
    logic [31:0] m_pc;

    int n_cmp = 0;
    int n_bad = 0;
    bit spurious_resp = 0;

    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_ipc;

    typedef struct {
        logic        st, fl;
        logic [31:0] fa;
        logic        br;
        logic [31:0] ba;
        logic        rr, re, ir;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mem_q.delete();
        m_pc = 32'hBFC0_0000;
    endtask

    task automatic cycle(input logic st, input logic fl, input logic [31:0] fa,
                         input logic br, input logic [31:0] ba,
                         input logic rr, input logic re, input logic ir);
        logic        e_rv, e_iv, redir, do_fill, do_pop;
        logic [31:0] tgt;
        stall = st; flush_en = fl; flush_addr = fa;
        branch_flag = br; branch_addr = ba;
        req_ready = rr; inst_ready = ir;
        if (re && mem_q.size() > 0) begin
            resp_valid = 1'b1;
            resp_data  = hash(mem_q[0]);
        end else if (re && spurious_resp && ($urandom_range(3) == 0)) begin
            resp_valid = 1'b1;
            resp_data  = $urandom;
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        #2;
        redir = fl | br;
        e_rv  = !st && !redir && (mq.size() < DEPTH);
        e_iv  = (mq.size() > 0) && mq[0].filled && !mq[0].stale;
        chk("req_valid", {31'd0, req_valid}, {31'd0, e_rv});
        chk("req_addr", req_addr, m_pc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, e_iv});
        if (e_iv) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_data", inst_data, hash(mq[0].pc));
        end
        s_rv = req_valid; s_ra = req_addr; s_iv = inst_valid; s_ipc = inst_pc;

        do_pop  = (mq.size() > 0) && mq[0].filled && (mq[0].stale || ir);
        do_fill = re && (mem_q.size() > 0);
        if (do_fill) begin
            void'(mem_q.pop_front());
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].filled) begin
                    mq[i].filled = 1'b1;
                    break;
                end
            end
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (redir) begin
            tgt  = fl ? fa : ba;
            m_pc = tgt & 32'hFFFF_FFFC;
        end else if (e_rv && rr) begin
            mq.push_back('{pc: m_pc, filled: 1'b0, stale: 1'b0});
            mem_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_addr", req_addr, 32'hBFC0_0000);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        stall = 1'b0; flush_en = 1'b0; branch_flag = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; inst_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int n_req;
        int n_stale_seen;
        rst = 1'b1;
        stall = 1'b0; flush_en = 1'b0; branch_flag = 1'b0;
        flush_addr = '0; branch_addr = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("por_req_valid", {31'd0, req_valid}, 32'd0);
        chk("por_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("por_inst_pc", inst_pc, 32'd0);
        chk("por_inst_data", inst_data, 32'd0);
        chk("por_pc", req_addr, 32'hBFC0_0000);
        rst = 1'b0;

        // st fl fa br ba rr re ir | req_valid req_addr inst_valid inst_pc
        tbl[0]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC00000,1'b0,32'd0};
        tbl[1]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC00004,1'b0,32'd0};
        tbl[2]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC00008,1'b1,32'hBFC00000};
        tbl[3]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC0000C,1'b1,32'hBFC00004};
        tbl[4]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b0,1'b0,1'b1, 1'b1,32'hBFC00010,1'b1,32'hBFC00008};
        tbl[5]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b0,1'b0,1'b1, 1'b1,32'hBFC00010,1'b0,32'd0};
        tbl[6]  = '{1'b0,1'b0,32'd0,1'b1,32'h80000102,1'b1,1'b1,1'b1, 1'b0,32'hBFC00010,1'b0,32'd0};
        tbl[7]  = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b0, 1'b1,32'h80000100,1'b0,32'd0};
        tbl[8]  = '{1'b0,1'b1,32'hBFC00380,1'b1,32'h12345678,1'b1,1'b1,1'b1, 1'b0,32'h80000104,1'b0,32'd0};
        tbl[9]  = '{1'b1,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b0,32'hBFC00380,1'b0,32'd0};
        tbl[10] = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC00380,1'b0,32'd0};
        tbl[11] = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hBFC00384,1'b0,32'd0};
        tbl[12] = '{1'b0,1'b1,32'hFFFFFFFC,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b0,32'hBFC00388,1'b1,32'hBFC00380};
        tbl[13] = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'hFFFFFFFC,1'b0,32'd0};
        tbl[14] = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'h00000000,1'b0,32'd0};
        tbl[15] = '{1'b0,1'b0,32'd0,1'b0,32'd0,1'b1,1'b1,1'b1, 1'b1,32'h00000004,1'b1,32'hFFFFFFFC};

        for (int v = 0; v < 16; v++) begin
            cycle(tbl[v].st, tbl[v].fl, tbl[v].fa, tbl[v].br, tbl[v].ba,
                  tbl[v].rr, tbl[v].re, tbl[v].ir);
            chk($sformatf("tbl%0d_req_valid", v), {31'd0, s_rv}, {31'd0, tbl[v].e_rv});
            chk($sformatf("tbl%0d_req_addr", v), s_ra, tbl[v].e_ra);
            chk($sformatf("tbl%0d_inst_valid", v), {31'd0, s_iv}, {31'd0, tbl[v].e_iv});
            if (tbl[v].e_iv) chk($sformatf("tbl%0d_inst_pc", v), s_ipc, tbl[v].e_ipc);
        end

        // Memory not ready: PC must hold at the reset vector.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("noready_addr", s_ra, 32'hBFC0_0000);
        chk("noready_inst_valid", {31'd0, s_iv}, 32'd0);

        // Decode blocked: only QUEUE_DEPTH requests may issue.
        do_reset();
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            if (s_rv) n_req++;
        end
        chk("full_issue_count", 32'(n_req), 32'd4);
        chk("full_req_valid", {31'd0, s_rv}, 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // Three fetches in flight when a branch arrives: none may reach decode.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0102, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        chk("branch_target_addr", s_ra, 32'h8000_0100);
        n_stale_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            if (s_iv && s_ipc[31:16] == 16'hBFC0) n_stale_seen++;
        end
        chk("branch_stale_delivered", 32'(n_stale_seen), 32'd0);

        // Random traffic with periodic mid-burst resets.
        spurious_resp = 1;
        for (int i = 0; i < 3000; i++) begin
            logic st, fl, br, rr, re, ir;
            st = ($urandom_range(7) == 0);
            fl = ($urandom_range(24) == 0);
            br = ($urandom_range(15) == 0);
            rr = ($urandom_range(3) != 0);
            re = ($urandom_range(1) == 0);
            ir = ($urandom_range(3) != 0);
            cycle(st, fl, $urandom, br, $urandom, rr, re, ir);
            if (i % 700 == 699) do_reset();
        end
        spurious_resp = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
